// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for load-use bubbles, taken-branch squash and data-memory freeze with timeout.
//   inputs : clk, rst (sync, active-high), rs1_IF_ID, rs2_IF_ID, rd_ID_EX, mem_read_ID_EX,
//            branch_taken_EX, dmem_req_EX_MEM, dmem_ready
//   outputs: pc_en, en_IF_ID/ID_EX/EX_MEM/MEM_WB, flush_IF_ID/ID_EX/MEM_WB, mem_timeout,
//            stall_cycles, flush_events (built only with HAZARD_PERF_CNT_EN, else 0)
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255,
  parameter int WAIT_W     = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_IF_ID,
  input  logic [REG_ADDR_W-1:0] rs2_IF_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID_EX,
  input  logic                  mem_read_ID_EX,
  input  logic                  branch_taken_EX,
  input  logic                  dmem_req_EX_MEM,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  en_IF_ID,
  output logic                  en_ID_EX,
  output logic                  en_EX_MEM,
  output logic                  en_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  flush_MEM_WB,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t r_state, w_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic w_mem_stall, w_load_use, w_err, w_act, w_ms, w_br, w_lu;
  assign w_mem_stall = dmem_req_EX_MEM & ~dmem_ready;
  assign w_load_use  = mem_read_ID_EX & (rd_ID_EX != '0) &
                       ((rd_ID_EX == rs1_IF_ID) | (rd_ID_EX == rs2_IF_ID));
  // reset overrides everything, then ERROR freezes, then the priority chain
  assign w_err = ~rst & (r_state == ERROR);
  assign w_act = ~rst & ~w_err;
  assign w_ms  = w_act & w_mem_stall;
  assign w_br  = w_act & ~w_mem_stall & branch_taken_EX;
  assign w_lu  = w_act & ~w_mem_stall & ~branch_taken_EX & w_load_use;
  assign pc_en        = ~(w_err | w_ms | w_lu);
  assign en_IF_ID     = ~(w_err | w_ms | w_lu);
  assign en_ID_EX     = ~(w_err | w_ms);
  assign en_EX_MEM    = ~(w_err | w_ms);
  assign en_MEM_WB    = ~w_err;
  assign flush_IF_ID  = w_br;
  assign flush_ID_EX  = w_br | w_lu;
  assign flush_MEM_WB = w_ms;
  assign mem_timeout  = w_err;
  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    case (r_state)
      RUN: begin
        w_next      = w_mem_stall ? MEM_WAIT : RUN;
        w_wait_next = w_mem_stall ? WAIT_W'(1) : '0;
      end
      MEM_WAIT: begin
        w_next      = !w_mem_stall ? RUN :
                      (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? ERROR : MEM_WAIT;
        w_wait_next = !w_mem_stall ? '0 :
                      (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
      end
      ERROR: w_next = ERROR;
      default: begin
        w_next      = RUN;
        w_wait_next = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(!pc_en);
      r_flush_events <= r_flush_events + CNT_W'(w_br);
    end
  end
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule
